// File: rtl/sdram_pkg.sv
// rtl/sdram_pkg.sv - shared arbiter state encoding and default SDRAM timing constants
package sdram_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    ACCESS  = 2'd2,
    REFRESH = 2'd3
  } arb_state_t;

  // 390 cycles is 7.8 us at 50 MHz
  localparam int REFRESH_INTERVAL_DEF = 390;
  localparam int MAX_DEBT_DEF         = 8;
  localparam int URGENT_DEBT_DEF      = 4;

endpackage

// File: rtl/refresh_scheduler.sv
// rtl/refresh_scheduler.sv - refresh interval timer, refresh debt counter and overflow flag
module refresh_scheduler
  import sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int MAX_DEBT         = MAX_DEBT_DEF
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       tick_en,
  input  logic       refresh_done,
  output logic [3:0] debt,
  output logic       refresh_overflow
);

  localparam int             TW       = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0]  RELOAD   = TW'(REFRESH_INTERVAL - 1);
  localparam logic [3:0]     DEBT_MAX = 4'(MAX_DEBT);

  logic [TW-1:0] timer;
  logic          tick;

  assign tick = tick_en && (timer == '0);

  // Interval timer: counts down while the SDRAM is initialised, reloads on tick
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      timer <= RELOAD;
    end else if (tick_en) begin
      timer <= (timer == '0) ? RELOAD : timer - TW'(1);
    end
  end

  // Debt counter: tick adds, completed refresh subtracts, both together cancel
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      debt             <= 4'd0;
      refresh_overflow <= 1'b0;
    end else if (tick && !refresh_done) begin
      if (debt == DEBT_MAX) begin
        refresh_overflow <= 1'b1;
      end else begin
        debt <= debt + 4'd1;
      end
    end else if (refresh_done && !tick && (debt != 4'd0)) begin
      debt <= debt - 4'd1;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin Zorro/DMA arbiter with refresh-debt scheduling for the SDRAM sequencer
module sdram_arbiter
  import sdram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEF,
  parameter int MAX_DEBT         = MAX_DEBT_DEF,
  parameter int URGENT_DEBT      = URGENT_DEBT_DEF
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       init_done,
  input  logic       req_z,
  input  logic       req_d,
  output logic       grant_z,
  output logic       grant_d,
  output logic       done_z,
  output logic       done_d,
  output logic       seq_start,
  output logic       seq_refresh,
  input  logic       seq_done,
  output logic       refresh_overflow,
  output logic [3:0] debt
);

  localparam logic [3:0] URGENT_L = 4'(URGENT_DEBT);

  arb_state_t state, state_n;
  logic       last_z, last_z_n;
  logic       grant_z_n, grant_d_n, done_z_n, done_d_n;
  logic       seq_start_n, seq_refresh_n;
  logic       refresh_done;

  // Only a seq_done that ends a refresh pays back debt
  assign refresh_done = (state == REFRESH) && seq_done;

  refresh_scheduler #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .MAX_DEBT         (MAX_DEBT)
  ) u_refresh_scheduler (
    .CLK              (CLK),
    .RESET_n          (RESET_n),
    .tick_en          (init_done),
    .refresh_done     (refresh_done),
    .debt             (debt),
    .refresh_overflow (refresh_overflow)
  );

  // State and registered outputs; last winner resets to DMA so Zorro wins first
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      state       <= IDLE;
      last_z      <= 1'b0;
      grant_z     <= 1'b0;
      grant_d     <= 1'b0;
      done_z      <= 1'b0;
      done_d      <= 1'b0;
      seq_start   <= 1'b0;
      seq_refresh <= 1'b0;
    end else begin
      state       <= state_n;
      last_z      <= last_z_n;
      grant_z     <= grant_z_n;
      grant_d     <= grant_d_n;
      done_z      <= done_z_n;
      done_d      <= done_d_n;
      seq_start   <= seq_start_n;
      seq_refresh <= seq_refresh_n;
    end
  end

  // Next state: urgent refresh, then round-robin grant, then opportunistic refresh
  always_comb begin
    state_n       = state;
    last_z_n      = last_z;
    grant_z_n     = grant_z;
    grant_d_n     = grant_d;
    done_z_n      = 1'b0;
    done_d_n      = 1'b0;
    seq_start_n   = 1'b0;
    seq_refresh_n = 1'b0;
    case (state)
      IDLE: begin
        if (init_done) begin
          if (debt >= URGENT_L) begin
            seq_refresh_n = 1'b1;
            state_n       = REFRESH;
          end else if (req_z || req_d) begin
            if (req_z && (!req_d || !last_z)) begin
              grant_z_n = 1'b1;
            end else begin
              grant_d_n = 1'b1;
            end
            state_n = GRANT;
          end else if (debt != 4'd0) begin
            seq_refresh_n = 1'b1;
            state_n       = REFRESH;
          end
        end
      end
      GRANT: begin
        seq_start_n = 1'b1;
        state_n     = ACCESS;
      end
      ACCESS: begin
        if (seq_done) begin
          done_z_n  = grant_z;
          done_d_n  = grant_d;
          grant_z_n = 1'b0;
          grant_d_n = 1'b0;
          last_z_n  = grant_z;
          state_n   = IDLE;
        end
      end
      REFRESH: begin
        if (seq_done) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
